// File: rtl/montprod_arbiter_if.sv
// Requester-side channel for the montprod arbiter: start/length handshake plus operand and result memory ports.
// Latency: none; this file only bundles signals.
// Backpressure: busy tells the requester a start would be dropped; no other flow control.
interface montprod_arbiter_if;
  logic        start;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  opa_addr;
  logic [7:0]  opb_addr;
  logic [7:0]  opm_addr;
  logic [31:0] opa_data;
  logic [31:0] opb_data;
  logic [31:0] opm_data;
  logic [7:0]  result_addr;
  logic [31:0] result_data;
  logic        result_we;

  // requester side
  modport master (
    output start, length, opa_data, opb_data, opm_data,
    input  busy, done, opa_addr, opb_addr, opm_addr, result_addr, result_data, result_we
  );

  // arbiter side
  modport slave (
    input  start, length, opa_data, opb_data, opm_data,
    output busy, done, opa_addr, opb_addr, opm_addr, result_addr, result_data, result_we
  );
endinterface

// File: rtl/montprod_arbiter.sv
// Shares one montprod core between two requesters, granting one at a time in round-robin order.
// Latency: start at edge t gives busy from t+1 and mp_calculate at t+2; memory routing is purely combinational.
// Backpressure: a start while busy or with zero length is dropped; a latched request waits until granted.
module montprod_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  montprod_arbiter_if.slave req0,
  montprod_arbiter_if.slave req1,
  output logic              mp_calculate,
  output logic [7:0]        mp_length,
  input  logic              mp_ready,
  input  logic [7:0]        mp_opa_addr,
  input  logic [7:0]        mp_opb_addr,
  input  logic [7:0]        mp_opm_addr,
  output logic [31:0]       mp_opa_data,
  output logic [31:0]       mp_opb_data,
  output logic [31:0]       mp_opm_data,
  input  logic [7:0]        mp_result_addr,
  input  logic [31:0]       mp_result_data,
  input  logic              mp_result_we,
  output logic              grant_valid,
  output logic              grant_id
);

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] pending;
  logic [7:0]         len0;
  logic [7:0]         len1;
  logic               last_grant;
  logic               owner0;
  logic               owner1;
  logic               acc0;
  logic               acc1;
  logic               take;
  logic               sel_id;

  // A requester that currently owns the core may not queue a second product behind itself.
  assign owner0 = (state != IDLE) && !grant_id;
  assign owner1 = (state != IDLE) && grant_id;
  assign acc0   = req0.start && !pending[0] && !owner0 && (req0.length != 8'd0);
  assign acc1   = req1.start && !pending[1] && !owner1 && (req1.length != 8'd0);
  assign take   = (state == IDLE) && (pending != '0);
  // On a tie the requester that was not served last wins.
  assign sel_id = (&pending) ? ~last_grant : pending[1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: one calculate cycle, then wait for the core to drop and re-raise ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pending != '0) state_nxt = START;
      START:    state_nxt = WAIT_LOW;
      WAIT_LOW: if (!mp_ready) state_nxt = RUN;
      RUN:      if (mp_ready) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request latching, grant capture and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      len0       <= 8'd0;
      len1       <= 8'd0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      mp_length  <= 8'd0;
    end else begin
      if (take) begin
        grant_id         <= sel_id;
        mp_length        <= sel_id ? len1 : len0;
        pending[sel_id]  <= 1'b0;
      end
      if (acc0) begin
        pending[0] <= 1'b1;
        len0       <= req0.length;
      end
      if (acc1) begin
        pending[1] <= 1'b1;
        len1       <= req1.length;
      end
      if (state == DONE) last_grant <= grant_id;
    end
  end

  // Outputs: handshake, status and owner-only memory routing; everything else is held at zero.
  always_comb begin
    grant_valid      = (state != IDLE);
    mp_calculate     = (state == START);
    req0.done        = (state == DONE) && !grant_id;
    req1.done        = (state == DONE) && grant_id;
    req0.busy        = pending[0] || owner0;
    req1.busy        = pending[1] || owner1;
    mp_opa_data      = 32'd0;
    mp_opb_data      = 32'd0;
    mp_opm_data      = 32'd0;
    req0.opa_addr    = 8'd0;
    req0.opb_addr    = 8'd0;
    req0.opm_addr    = 8'd0;
    req0.result_addr = 8'd0;
    req0.result_data = 32'd0;
    req0.result_we   = 1'b0;
    req1.opa_addr    = 8'd0;
    req1.opb_addr    = 8'd0;
    req1.opm_addr    = 8'd0;
    req1.result_addr = 8'd0;
    req1.result_data = 32'd0;
    req1.result_we   = 1'b0;
    if (owner0) begin
      mp_opa_data      = req0.opa_data;
      mp_opb_data      = req0.opb_data;
      mp_opm_data      = req0.opm_data;
      req0.opa_addr    = mp_opa_addr;
      req0.opb_addr    = mp_opb_addr;
      req0.opm_addr    = mp_opm_addr;
      req0.result_addr = mp_result_addr;
      req0.result_data = mp_result_data;
      req0.result_we   = mp_result_we;
    end
    if (owner1) begin
      mp_opa_data      = req1.opa_data;
      mp_opb_data      = req1.opb_data;
      mp_opm_data      = req1.opm_data;
      req1.opa_addr    = mp_opa_addr;
      req1.opb_addr    = mp_opb_addr;
      req1.opm_addr    = mp_opm_addr;
      req1.result_addr = mp_result_addr;
      req1.result_data = mp_result_data;
      req1.result_we   = mp_result_we;
    end
  end

endmodule
